memory_access_stage: RTL and testbench

//  Pipeline stage between execute and WritebackStage. Accepts one instruction

---
 rtl/memory_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// memory_access_stage: executes loads/stores on the data-memory req/ack bus and
// registers the commit bundle for the writeback stage.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_ex_* / o_ex_ready         instruction from execute (valid/ready handshake)
//   o_dmem_* / i_dmem_*         data-memory request/acknowledge bus
//   o_wb_* / o_wb_valid         registered commit bundle; tags and psr_updated
//                               are 0 whenever o_wb_valid is 0
//   o_mem_fault                 one-cycle pulse on misaligned access or bus error
module memory_access_stage #(
    parameter int TAG_W  = 4,
    parameter int WORD_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ex_valid,
    output logic                  o_ex_ready,
    input  logic [TAG_W-1:0]      i_ex_result_tag,
    input  logic [WORD_W-1:0]     i_ex_result_value,
    input  logic [TAG_W-1:0]      i_ex_autoinc_tag,
    input  logic [WORD_W-1:0]     i_ex_autoinc_value,
    input  logic [3:0]            i_ex_psr_value,
    input  logic                  i_ex_psr_updated,
    input  logic [1:0]            i_ex_mem_op,
    input  logic [1:0]            i_ex_mem_size,
    input  logic                  i_ex_mem_signed,
    input  logic [WORD_W-1:0]     i_ex_store_data,
    output logic                  o_dmem_req,
    output logic                  o_dmem_write,
    output logic [WORD_W-1:0]     o_dmem_addr,
    output logic [WORD_W-1:0]     o_dmem_wdata,
    output logic [WORD_W/8-1:0]   o_dmem_byte_en,
    input  logic                  i_dmem_ack,
    input  logic [WORD_W-1:0]     i_dmem_rdata,
    input  logic                  i_dmem_err,
    output logic [TAG_W-1:0]      o_wb_result_tag,
    output logic [WORD_W-1:0]     o_wb_result_value,
    output logic [TAG_W-1:0]      o_wb_autoinc_tag,
    output logic [WORD_W-1:0]     o_wb_autoinc_value,
    output logic [3:0]            o_wb_psr_value,
    output logic                  o_wb_psr_updated,
    output logic                  o_wb_valid,
    output logic                  o_mem_fault
);
    localparam int BE_W = WORD_W / 8;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t              r_state;
    logic                r_dmem_write;
    logic [WORD_W-1:0]   r_dmem_addr;
    logic [WORD_W-1:0]   r_dmem_wdata;
    logic [BE_W-1:0]     r_dmem_be;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [TAG_W-1:0]    r_res_tag;
    logic [TAG_W-1:0]    r_ai_tag;
    logic [WORD_W-1:0]   r_ai_val;
    logic [3:0]          r_psr_val;
    logic                r_psr_upd;
    logic [TAG_W-1:0]    r_wb_res_tag;
    logic [WORD_W-1:0]   r_wb_res_val;
    logic [TAG_W-1:0]    r_wb_ai_tag;
    logic [WORD_W-1:0]   r_wb_ai_val;
    logic [3:0]          r_wb_psr_val;
    logic                r_wb_psr_upd;
    logic                r_wb_valid;
    logic                r_fault;
    logic                w_load;
    logic                w_store;
    logic                w_misal;
    logic [BE_W-1:0]     w_be;
    logic [WORD_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [WORD_W-1:0]   w_load_val;
    always_comb begin
        w_load     = i_ex_mem_op == 2'b01;
        w_store    = i_ex_mem_op == 2'b10;
        // Reserved size 11 behaves as word.
        w_misal    = i_ex_mem_size == 2'b00 ? 1'b0 :
                     i_ex_mem_size == 2'b01 ? i_ex_result_value[0] : |i_ex_result_value[1:0];
        w_be       = i_ex_mem_size == 2'b00 ? BE_W'(1) << i_ex_result_value[1:0] :
                     i_ex_mem_size == 2'b01 ? (i_ex_result_value[1] ? BE_W'(4'b1100) : BE_W'(4'b0011)) :
                     {BE_W{1'b1}};
        // Sub-word store data is replicated across lanes so the byte enables pick it out.
        w_wdata    = i_ex_mem_size == 2'b00 ? {BE_W{i_ex_store_data[7:0]}} :
                     i_ex_mem_size == 2'b01 ? {(BE_W/2){i_ex_store_data[15:0]}} : i_ex_store_data;
        w_byte     = i_dmem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = i_dmem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load_val = r_size == 2'b00 ? {{(WORD_W-8){r_signed & w_byte[7]}}, w_byte} :
                     r_size == 2'b01 ? {{(WORD_W-16){r_signed & w_half[15]}}, w_half} : i_dmem_rdata;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_dmem_write <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= '0;
            r_lane       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_res_tag    <= '0;
            r_ai_tag     <= '0;
            r_ai_val     <= '0;
            r_psr_val    <= '0;
            r_psr_upd    <= 1'b0;
            r_wb_res_tag <= '0;
            r_wb_res_val <= '0;
            r_wb_ai_tag  <= '0;
            r_wb_ai_val  <= '0;
            r_wb_psr_val <= '0;
            r_wb_psr_upd <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            // Default: nothing retires, so commit tags are cleared; values are left as-is.
            r_wb_valid   <= 1'b0;
            r_fault      <= 1'b0;
            r_wb_res_tag <= '0;
            r_wb_ai_tag  <= '0;
            r_wb_psr_upd <= 1'b0;
            if (r_state == IDLE && i_ex_valid) begin
                if (!(w_load || w_store)) begin
                    r_wb_valid   <= 1'b1;
                    r_wb_res_tag <= i_ex_result_tag;
                    r_wb_res_val <= i_ex_result_value;
                    r_wb_ai_tag  <= i_ex_autoinc_tag;
                    r_wb_ai_val  <= i_ex_autoinc_value;
                    r_wb_psr_val <= i_ex_psr_value;
                    r_wb_psr_upd <= i_ex_psr_updated;
                end else if (w_misal) begin
                    r_wb_valid <= 1'b1;
                    r_fault    <= 1'b1;
                end else begin
                    r_state      <= ACCESS;
                    r_dmem_write <= w_store;
                    r_dmem_addr  <= {i_ex_result_value[WORD_W-1:2], 2'b00};
                    r_dmem_wdata <= w_wdata;
                    r_dmem_be    <= w_be;
                    r_lane       <= i_ex_result_value[1:0];
                    r_size       <= i_ex_mem_size;
                    r_signed     <= i_ex_mem_signed;
                    r_res_tag    <= w_store ? '0 : i_ex_result_tag;
                    r_ai_tag     <= i_ex_autoinc_tag;
                    r_ai_val     <= i_ex_autoinc_value;
                    r_psr_val    <= i_ex_psr_value;
                    r_psr_upd    <= i_ex_psr_updated;
                end
            end else if (r_state == ACCESS && i_dmem_ack) begin
                r_state    <= IDLE;
                r_wb_valid <= 1'b1;
                if (i_dmem_err) begin
                    r_fault <= 1'b1;
                end else begin
                    r_wb_res_tag <= r_res_tag;
                    r_wb_res_val <= w_load_val;
                    r_wb_ai_tag  <= r_ai_tag;
                    r_wb_ai_val  <= r_ai_val;
                    r_wb_psr_val <= r_psr_val;
                    r_wb_psr_upd <= r_psr_upd;
                end
            end
        end
    end
    assign o_ex_ready         = r_state == IDLE;
    assign o_dmem_req         = r_state == ACCESS;
    assign o_dmem_write       = r_dmem_write;
    assign o_dmem_addr        = r_dmem_addr;
    assign o_dmem_wdata       = r_dmem_wdata;
    assign o_dmem_byte_en     = r_dmem_be;
    assign o_wb_result_tag    = r_wb_res_tag;
    assign o_wb_result_value  = r_wb_res_val;
    assign o_wb_autoinc_tag   = r_wb_ai_tag;
    assign o_wb_autoinc_value = r_wb_ai_val;
    assign o_wb_psr_value     = r_wb_psr_val;
    assign o_wb_psr_updated   = r_wb_psr_upd;
    assign o_wb_valid         = r_wb_valid;
    assign o_mem_fault        = r_fault;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed-vector bench for memory_access_stage.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_result_tag;
    logic [31:0] ex_result_value;
    logic [3:0]  ex_autoinc_tag;
    logic [31:0] ex_autoinc_value;
    logic [3:0]  ex_psr_value;
    logic        ex_psr_updated;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_signed;
    logic [31:0] ex_store_data;
    logic        dmem_req;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic [3:0]  wb_result_tag;
    logic [31:0] wb_result_value;
    logic [3:0]  wb_autoinc_tag;
    logic [31:0] wb_autoinc_value;
    logic [3:0]  wb_psr_value;
    logic        wb_psr_updated;
    logic        wb_valid;
    logic        mem_fault;
    int          n_cmp = 0;
    int          n_bad = 0;

    memory_access_stage dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
        .i_ex_result_tag(ex_result_tag), .i_ex_result_value(ex_result_value),
        .i_ex_autoinc_tag(ex_autoinc_tag), .i_ex_autoinc_value(ex_autoinc_value),
        .i_ex_psr_value(ex_psr_value), .i_ex_psr_updated(ex_psr_updated),
        .i_ex_mem_op(ex_mem_op), .i_ex_mem_size(ex_mem_size),
        .i_ex_mem_signed(ex_mem_signed), .i_ex_store_data(ex_store_data),
        .o_dmem_req(dmem_req), .o_dmem_write(dmem_write), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_byte_en(dmem_byte_en),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .i_dmem_err(dmem_err),
        .o_wb_result_tag(wb_result_tag), .o_wb_result_value(wb_result_value),
        .o_wb_autoinc_tag(wb_autoinc_tag), .o_wb_autoinc_value(wb_autoinc_value),
        .o_wb_psr_value(wb_psr_value), .o_wb_psr_updated(wb_psr_updated),
        .o_wb_valid(wb_valid), .o_mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [3:0] tag, input logic [31:0] val,
                         input logic [3:0] ai_tag, input logic [31:0] ai_val,
                         input logic [3:0] psr, input logic psr_upd, input logic [31:0] sdata);
        ex_valid = 1'b1; ex_mem_op = op; ex_mem_size = size; ex_mem_signed = sgn;
        ex_result_tag = tag; ex_result_value = val;
        ex_autoinc_tag = ai_tag; ex_autoinc_value = ai_val;
        ex_psr_value = psr; ex_psr_updated = psr_upd; ex_store_data = sdata;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        issue(2'b00, 2'b00, 1'b0, 4'd0, 32'h0, 4'd0, 32'h0, 4'h0, 1'b0, 32'h0);
        ex_valid = 1'b0;
        step(); step();
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_wb_tag", wb_result_tag, 0);
        chk("rst_byte_en", dmem_byte_en, 0);
        rst_n = 1'b1;
        step();

        // four back-to-back ALU ops
        issue(2'b00, 2'b00, 1'b0, 4'd3, 32'h1234, 4'd0, 32'h0, 4'hA, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_tag", wb_result_tag, 3);
            chk("alu_value", wb_result_value, 32'h1234);
            chk("alu_ex_ready", ex_ready, 1);
            chk("alu_psr", {wb_psr_updated, wb_psr_value}, 5'h1A);
        end
        ex_valid = 1'b0;
        step();
        chk("alu_idle_valid", wb_valid, 0);
        chk("alu_idle_tag", wb_result_tag, 0);
        chk("alu_idle_psr_upd", wb_psr_updated, 0);

        // signed byte load at 0x103, ack on fourth access cycle
        issue(2'b01, 2'b00, 1'b1, 4'd7, 32'h103, 4'd0, 32'h0, 4'h0, 1'b0, 32'h0);
        step();
        ex_valid = 1'b0;
        chk("lb_req", dmem_req, 1);
        chk("lb_write", dmem_write, 0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", dmem_byte_en, 4'b1000);
        chk("lb_ex_ready0", ex_ready, 0);
        chk("lb_no_wb", wb_valid, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("lb_req_held", dmem_req, 1);
            chk("lb_addr_held", dmem_addr, 32'h100);
            chk("lb_ex_ready_low", ex_ready, 0);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
        step();
        dmem_ack = 1'b0;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_tag", wb_result_tag, 7);
        chk("lb_value", wb_result_value, 32'hFFFF_FF80);
        chk("lb_ex_ready", ex_ready, 1);
        chk("lb_req_drop", dmem_req, 0);
        chk("lb_fault", mem_fault, 0);

        // half store 0xBEEF at 0x202 with auto-increment
        issue(2'b10, 2'b01, 1'b0, 4'd9, 32'h202, 4'd2, 32'h206, 4'h0, 1'b0, 32'h0000_BEEF);
        step();
        ex_valid = 1'b0;
        chk("sh_req", dmem_req, 1);
        chk("sh_write", dmem_write, 1);
        chk("sh_addr", dmem_addr, 32'h200);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_be", dmem_byte_en, 4'b1100);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sh_wb_valid", wb_valid, 1);
        chk("sh_tag", wb_result_tag, 0);
        chk("sh_ai_tag", wb_autoinc_tag, 2);
        chk("sh_ai_val", wb_autoinc_value, 32'h206);

        // misaligned word load
        issue(2'b01, 2'b10, 1'b0, 4'd4, 32'h101, 4'd5, 32'h105, 4'h3, 1'b1, 32'h0);
        step();
        ex_valid = 1'b0;
        chk("mis_req", dmem_req, 0);
        chk("mis_ex_ready", ex_ready, 1);
        chk("mis_fault", mem_fault, 1);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_tag", wb_result_tag, 0);
        chk("mis_ai_tag", wb_autoinc_tag, 0);
        chk("mis_psr_upd", wb_psr_updated, 0);
        step();
        chk("mis_fault_pulse", mem_fault, 0);
        chk("mis_wb_drop", wb_valid, 0);

        // unsigned half load at 0x102
        issue(2'b01, 2'b01, 1'b0, 4'd6, 32'h102, 4'd0, 32'h0, 4'h0, 1'b0, 32'h0);
        step();
        ex_valid = 1'b0;
        chk("lhu_be", dmem_byte_en, 4'b1100);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
        step();
        dmem_ack = 1'b0;
        chk("lhu_value", wb_result_value, 32'h0000_80FF);
        chk("lhu_tag", wb_result_tag, 6);

        // load terminated by bus error
        issue(2'b01, 2'b10, 1'b0, 4'd8, 32'h300, 4'd3, 32'h304, 4'h0, 1'b1, 32'h0);
        step();
        ex_valid = 1'b0;
        dmem_ack = 1'b1; dmem_err = 1'b1;
        step();
        dmem_ack = 1'b0; dmem_err = 1'b0;
        chk("err_fault", mem_fault, 1);
        chk("err_wb_valid", wb_valid, 1);
        chk("err_tag", wb_result_tag, 0);
        chk("err_ai_tag", wb_autoinc_tag, 0);
        chk("err_psr_upd", wb_psr_updated, 0);
        step();
        chk("err_fault_pulse", mem_fault, 0);

        // reset in the middle of an access
        issue(2'b01, 2'b10, 1'b0, 4'd2, 32'h400, 4'd0, 32'h0, 4'h0, 1'b0, 32'h0);
        step();
        ex_valid = 1'b0;
        chk("rm_req", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_req_async", dmem_req, 0);
        chk("rm_ex_ready", ex_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        chk("rm_idle_ready", ex_ready, 1);
        chk("rm_idle_req", dmem_req, 0);
        chk("rm_idle_wb", wb_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
